// File: rtl/serial_comp_acc_if.sv
// Bit-pair handshake and word-result bundle for serial_comp_acc.
// master drives the comparator flags; slave is the accumulator.
interface serial_comp_acc_if;
    logic start;
    logic bit_vld;
    logic x_in;
    logic y_in;
    logic z_in;
    logic busy;
    logic done;
    logic lt;
    logic eq;
    logic gt;
    logic err;

    modport master (
        output start, bit_vld, x_in, y_in, z_in,
        input  busy, done, lt, eq, gt, err
    );

    modport slave (
        input  start, bit_vld, x_in, y_in, z_in,
        output busy, done, lt, eq, gt, err
    );
endinterface

// File: rtl/serial_comp_acc.sv
// Serial MSB-first word comparator built from per-bit lt/eq/gt flags.
// Optional one-hot flag checking: define SERIAL_COMP_ONEHOT_CHK_EN.
module serial_comp_acc #(
    parameter int WIDTH = 4
) (
    input logic            clk,
    input logic            rst,
    serial_comp_acc_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          dec_set;
    logic          dec_gt;
    logic          accept;
    logic          last_bit;
    logic          bit_lt;
    logic          bit_gt;
    logic          fin_set;
    logic          fin_gt;
    logic          res_lt;
    logic          res_eq;
    logic          res_gt;
    logic          res_err;
    logic          lt_q;
    logic          eq_q;
    logic          gt_q;
    logic          busy_o;
    logic          done_o;

    // start wins over bit_vld, so a bit presented alongside start is dropped
    assign accept   = (state == RUN) && bus.bit_vld && !bus.start;
    assign last_bit = accept && (cnt == CW'(WIDTH - 1));
    assign bit_lt   = bus.x_in;
    assign bit_gt   = !bus.x_in && bus.z_in;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN: begin
                if (bus.start)     state_nxt = RUN;
                else if (last_bit) state_nxt = DONE;
            end
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state == RUN);
        done_o = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            dec_set <= 1'b0;
            dec_gt  <= 1'b0;
        end else if (bus.start) begin
            cnt     <= '0;
            dec_set <= 1'b0;
            dec_gt  <= 1'b0;
        end else if (accept) begin
            if (cnt != CW'(WIDTH)) cnt <= cnt + 1'b1;
            if (!dec_set && (bit_lt || bit_gt)) begin
                dec_set <= 1'b1;
                dec_gt  <= bit_gt;
            end
        end
    end

    // The last bit is folded in here because its decision is not yet registered
    assign fin_set = dec_set || bit_lt || bit_gt;
    assign fin_gt  = dec_set ? dec_gt : bit_gt;

`ifdef SERIAL_COMP_ONEHOT_CHK_EN
    logic bad_q;
    logic bit_bad;

    assign bit_bad = !$onehot({bus.x_in, bus.y_in, bus.z_in});

    always_ff @(posedge clk) begin
        if (rst || bus.start)      bad_q <= 1'b0;
        else if (accept && bit_bad) bad_q <= 1'b1;
    end

    always_comb begin
        res_err = bad_q || bit_bad;
        res_lt  = !res_err && fin_set && !fin_gt;
        res_gt  = !res_err && fin_set && fin_gt;
        res_eq  = !res_err && !fin_set;
    end

    logic err_q;

    always_ff @(posedge clk) begin
        if (rst)           err_q <= 1'b0;
        else if (last_bit) err_q <= res_err;
    end

    assign bus.err = err_q;
`else
    logic unused_y;

    assign unused_y = bus.y_in;

    always_comb begin
        res_err = 1'b0;
        res_lt  = fin_set && !fin_gt;
        res_gt  = fin_set && fin_gt;
        res_eq  = !fin_set;
    end

    assign bus.err = res_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            lt_q <= 1'b0;
            eq_q <= 1'b0;
            gt_q <= 1'b0;
        end else if (last_bit) begin
            lt_q <= res_lt;
            eq_q <= res_eq;
            gt_q <= res_gt;
        end
    end

    assign bus.busy = busy_o;
    assign bus.done = done_o;
    assign bus.lt   = lt_q;
    assign bus.eq   = eq_q;
    assign bus.gt   = gt_q;
endmodule

// File: tb/tb_serial_comp_acc.sv
// Self-checking bench for serial_comp_acc: directed word scenarios plus
// randomized traffic compared every cycle against a queue-based word model.
module tb_serial_comp_acc;
    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    bit   chk_en;

    serial_comp_acc_if bus ();

    serial_comp_acc #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-level model: collects accepted bit triples and judges a full word
    bit       m_in;
    bit       m_done;
    bit       m_lt, m_eq, m_gt, m_err;
    bit [2:0] m_q[$];
    int       dq[$];

    function automatic void judge_word();
        bit bad = 0;
        int first = 0;
        foreach (m_q[i]) begin
            if ($countones(m_q[i]) != 1) bad = 1;
            if (first == 0) begin
                if (m_q[i][2])      first = 1;
                else if (m_q[i][0]) first = 2;
            end
        end
`ifdef SERIAL_COMP_ONEHOT_CHK_EN
        if (bad) begin
            {m_lt, m_eq, m_gt, m_err} = 4'b0001;
            return;
        end
`endif
        m_lt  = (first == 1);
        m_gt  = (first == 2);
        m_eq  = (first == 0);
        m_err = 1'b0;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_in   = 0;
            m_done = 0;
            m_q.delete();
            {m_lt, m_eq, m_gt, m_err} = 4'b0000;
        end else begin
            m_done = 0;
            if (bus.start) begin
                m_in = 1;
                m_q.delete();
            end else if (m_in && bus.bit_vld) begin
                m_q.push_back({bus.x_in, bus.y_in, bus.z_in});
                if (m_q.size() == WIDTH) begin
                    judge_word();
                    m_in   = 0;
                    m_done = 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done === 1'b1) dq.push_back(cyc);
        if (chk_en)
            checkOutput("cycle", {26'd0, bus.busy, bus.done, bus.lt, bus.eq, bus.gt, bus.err},
                        {26'd0, m_in, m_done, m_lt, m_eq, m_gt, m_err});
    end

    task automatic applyStimulus(input bit r, input bit s, input bit v, input bit [2:0] xyz);
        @(posedge clk);
        #1;
        rst         = r;
        bus.start   = s;
        bus.bit_vld = v;
        {bus.x_in, bus.y_in, bus.z_in} = xyz;
    endtask

    task automatic step();
        applyStimulus(0, 0, 0, 3'b000);
    endtask

    function automatic logic [31:0] outs();
        return {26'd0, bus.busy, bus.done, bus.lt, bus.eq, bus.gt, bus.err};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        chk_en = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.bit_vld = 1'b0;
        {bus.x_in, bus.y_in, bus.z_in} = 3'b000;
        @(posedge clk);
        #1;
        chk_en = 1;
        applyStimulus(1, 0, 0, 3'b000);
        applyStimulus(0, 0, 0, 3'b000);
        checkOutput("reset", outs(), 32'h00);

        // gt word: 010,010,001,100
        applyStimulus(0, 1, 0, 3'b000);
        applyStimulus(0, 0, 1, 3'b010);
        checkOutput("busy_run", {31'd0, bus.busy}, 32'd1);
        applyStimulus(0, 0, 1, 3'b010);
        applyStimulus(0, 0, 1, 3'b001);
        applyStimulus(0, 0, 1, 3'b100);
        checkOutput("no_early_done", {31'd0, bus.done}, 32'd0);
        step();
        checkOutput("gt_word", outs(), 32'b010010);
        step();
        checkOutput("gt_hold", outs(), 32'b000010);

        // eq word, then lt word where the first decision wins
        applyStimulus(0, 1, 0, 3'b000);
        repeat (4) applyStimulus(0, 0, 1, 3'b010);
        step();
        checkOutput("eq_word", outs(), 32'b010100);
        applyStimulus(0, 1, 0, 3'b000);
        applyStimulus(0, 0, 1, 3'b100);
        repeat (3) applyStimulus(0, 0, 1, 3'b001);
        step();
        checkOutput("lt_first_wins", outs(), 32'b011000);

        // abort mid-word, then bit_vld while idle must change nothing
        step();
        dq.delete();
        applyStimulus(0, 1, 0, 3'b000);
        repeat (2) applyStimulus(0, 0, 1, 3'b100);
        applyStimulus(0, 1, 1, 3'b100);
        repeat (4) applyStimulus(0, 0, 1, 3'b001);
        repeat (3) applyStimulus(0, 0, 1, 3'b100);
        step();
        checkOutput("abort_one_done", dq.size(), 32'd1);
        checkOutput("abort_gt_idle", outs(), 32'b000010);

        // reset mid-word
        dq.delete();
        applyStimulus(0, 1, 0, 3'b000);
        repeat (2) applyStimulus(0, 0, 1, 3'b001);
        applyStimulus(1, 0, 1, 3'b001);
        step();
        checkOutput("mid_reset", outs(), 32'h00);
        repeat (6) step();
        checkOutput("reset_no_done", dq.size(), 32'd0);

        // malformed 110 flag as the first bit
        applyStimulus(0, 1, 0, 3'b000);
        applyStimulus(0, 0, 1, 3'b110);
        repeat (3) applyStimulus(0, 0, 1, 3'b010);
        step();
`ifdef SERIAL_COMP_ONEHOT_CHK_EN
        checkOutput("bad_flag", outs(), 32'b010001);
`else
        checkOutput("bad_flag", outs(), 32'b011000);
`endif

        // start held in DONE gives back-to-back words
        step();
        dq.delete();
        applyStimulus(0, 1, 0, 3'b000);
        repeat (4) applyStimulus(0, 0, 1, 3'b001);
        applyStimulus(0, 1, 0, 3'b000);
        repeat (4) applyStimulus(0, 0, 1, 3'b010);
        repeat (2) step();
        checkOutput("b2b_count", dq.size(), 32'd2);
        if (dq.size() == 2) checkOutput("b2b_spacing", dq[1] - dq[0], WIDTH + 1);
        checkOutput("b2b_eq", outs(), 32'b000100);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit       r, s, v;
            bit [2:0] xyz;
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 11) == 0);
            v = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0) xyz = 3'($urandom_range(0, 7));
            else                           xyz = 3'b001 << $urandom_range(0, 2);
            applyStimulus(r, s, v, xyz);
        end
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_comp_acc.md
SERIAL_COMP_ACC -- requirements
Module: serial_comp_acc

Interface
REQ-001 Parameter: WIDTH, 4, number of bit-pair results per word (legal range 1..32).
REQ-002 Port: clk  input  1  rising-edge clock, the only clock.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  begin a new word; bits are accepted from the following cycle.
REQ-005 Port: bit_vld  input  1  x_in/y_in/z_in carry one bit-pair result this cycle.
REQ-006 Port: x_in  input  1  per-bit a<b flag from the upstream 1-bit comparator.
REQ-007 Port: y_in  input  1  per-bit a==b flag from the upstream 1-bit comparator.
REQ-008 Port: z_in  input  1  per-bit a>b flag from the upstream 1-bit comparator.
REQ-009 Port: busy  output  1  high while a word is being accumulated.
REQ-010 Port: done  output  1  one-cycle pulse when the word result is valid.
REQ-011 Port: lt  output  1  word a<b, registered.
REQ-012 Port: eq  output  1  word a==b, registered.
REQ-013 Port: gt  output  1  word a>b, registered.
REQ-014 Port: err  output  1  malformed flag seen in the word, registered (see REQ-030).

Function
REQ-015 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-016 FSM transitions SHALL be: IDLE->RUN on start; RUN->DONE on acceptance of the WIDTH-th bit; DONE->IDLE unconditionally after one cycle, or DONE->RUN if start is high in DONE.
REQ-017 busy SHALL be 1 exactly while in RUN.
REQ-018 Bits SHALL arrive MSB-first; a bit is accepted only in RUN with bit_vld=1.
REQ-019 bit_vld in IDLE or DONE SHALL be ignored.
REQ-020 The block SHALL keep a bit counter of ceil(log2(WIDTH+1)) bits; it clears on start and increments per accepted bit with no wrap past WIDTH.
REQ-021 An internal decision SHALL clear on start; the first accepted bit with x_in=1 or z_in=1 sets it to LT or GT, and later bits are ignored for the result.
REQ-022 If all WIDTH accepted bits have y_in=1, the result SHALL be EQ.
REQ-023 lt/eq/gt/err SHALL update on the same edge that raises done (one cycle after the WIDTH-th accepted bit's edge) and SHALL hold until the next done or reset.
REQ-024 Exactly one of lt/eq/gt SHALL be 1 after any done with err=0.
REQ-025 start during RUN SHALL abort the word: the counter and decision clear, no done pulse is produced, and RUN is kept.
REQ-026 When start and bit_vld are both high, start SHALL take precedence and that bit is not accepted.
REQ-027 When WIDTH=1, done SHALL follow the first accepted bit by one cycle.

Reset
REQ-028 On rst=1 at a clk edge, the block SHALL set state=IDLE, counter=0, decision cleared, busy=0, done=0, lt=0, eq=0, gt=0 and err=0.
REQ-029 rst SHALL override start and bit_vld; reset mid-word discards the word with no done pulse.

Configuration
REQ-030 With macro SERIAL_COMP_ONEHOT_CHK_EN defined, any accepted bit whose {x_in,y_in,z_in} is not one-hot SHALL set a sticky word-error; at done, err=1 and lt=eq=gt=0.
REQ-031 Without SERIAL_COMP_ONEHOT_CHK_EN, err SHALL be constant 0 and each bit SHALL be decoded with priority x_in (LT), then z_in (GT), else equal.

Verification
REQ-032 WIDTH=4, start, then bits (x,y,z)=010,010,001,100 -> done 1 cycle after the 4th bit; gt=1, lt=0, eq=0, err=0.
REQ-033 WIDTH=4, four bits of 010 -> eq=1; then a new word 100,001,001,001 -> lt=1 (first decision wins).
REQ-034 Start, two bits accepted, then start again, then four bits 001 -> exactly one done pulse, gt=1; bit_vld while IDLE changes nothing.
REQ-035 rst asserted after two accepted bits -> busy=0, done never pulses, all outputs 0 on the next cycle.
REQ-036 Bit 110 with the macro defined -> err=1, lt=eq=gt=0; without the macro -> lt=1, err=0.
REQ-037 start held high in DONE -> back-to-back words with done pulses WIDTH+1 cycles apart.
